// File: rtl/ppu_pkg.sv
// Types and limits shared between the PPU and the LCD-side byte packer.
package ppu_pkg;
  localparam int PPU_LINE_PX     = 160;
  localparam int PPU_FRAME_LINES = 144;

  typedef logic [1:0] px_t;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic [7:0] data;
  } lcd_entry_t;
endpackage

// File: rtl/ppu_lcd_packer_if.sv
// Packed-byte stream toward the LCD/host transport (valid/ready).
interface ppu_lcd_packer_if;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eol;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, out_sof, out_eol, out_valid, input out_ready);
  modport slave  (input out_data, out_sof, out_eol, out_valid, output out_ready);
endinterface

// File: rtl/ppu_byte_fifo.sv
// Byte FIFO with a registered head; an entry reaches the head one clk after push.
// full counts the head, so DEPTH is the total number of bytes held.
module ppu_byte_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  lcd_entry_t wr_entry,
  input  logic       pop,
  output lcd_entry_t head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  lcd_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   mem_cnt, total;
  logic          head_vld, do_pop, do_push, load;

  assign total   = mem_cnt + (AW+1)'(head_vld);
  assign full    = (total == (AW+1)'(DEPTH));
  assign empty   = !head_vld;
  assign do_pop  = pop && head_vld;
  // a pop frees a slot on the same edge, so push-at-full with pop is kept
  assign do_push = push && !flush && (!full || do_pop);
  assign load    = !flush && (mem_cnt != '0) && (!head_vld || do_pop);

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_entry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      head_vld <= 1'b0;
      head     <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      head_vld <= 1'b0;
      head     <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        head   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      head_vld <= load | (head_vld & ~do_pop);
      case ({do_push, load})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end
endmodule

// File: rtl/ppu_lcd_packer.sv
// Packs the PPU's 2-bit pixel stream four per byte into a FIFO-backed byte stream
// with frame/line markers; never stalls the PPU, flags overflow and bad lines.
module ppu_lcd_packer
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int LINE_PX     = PPU_LINE_PX,
  parameter int FRAME_LINES = PPU_FRAME_LINES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_on,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              px_out,
  input  px_t               px,
  ppu_lcd_packer_if.master  lcd,
  output logic              overflow,
  output logic              line_err,
  input  logic              err_clr
);
  localparam int XW = $clog2(LINE_PX + 1);
  localparam logic [XW-1:0] X_END  = XW'(LINE_PX);
  localparam logic [XW-1:0] X_LAST = XW'(LINE_PX - 1);
  localparam logic [7:0]    Y_END  = 8'(FRAME_LINES);

  logic          locked, locked_n;
  logic [XW-1:0] x, x_n;
  logic [7:0]    y, y_n;
  logic [7:0]    part, part_n;
  logic          push, pop, full, empty, le_evt, ovf_evt;
  lcd_entry_t    entry, head;

  always_comb begin
    locked_n = locked;
    x_n      = x;
    y_n      = y;
    part_n   = part;
    push     = 1'b0;
    entry    = '0;
    le_evt   = 1'b0;
    if (!disp_on) begin
      locked_n = 1'b0;
      x_n      = '0;
      y_n      = '0;
      part_n   = '0;
    end else begin
      // strobes first, so a coincident pixel lands at x=0 of the new line
      if (vsync) begin
        locked_n = 1'b1;
        x_n      = '0;
        y_n      = '0;
        part_n   = '0;
      end else if (hsync) begin
        if (x != '0 && x != X_END) le_evt = 1'b1;
        x_n    = '0;
        y_n    = (y == 8'hFF) ? y : y + 8'd1;
        part_n = '0;
      end
      if (px_out && locked_n) begin
        if (x_n < X_END && y_n < Y_END) begin
          case (x_n[1:0])
            2'd0: part_n[7:6] = px;
            2'd1: part_n[5:4] = px;
            2'd2: part_n[3:2] = px;
            2'd3: part_n[1:0] = px;
          endcase
          if (x_n[1:0] == 2'd3) begin
            push       = 1'b1;
            entry.sof  = (x_n == XW'(3)) && (y_n == 8'd0);
            entry.eol  = (x_n == X_LAST);
            entry.data = part_n;
          end
          x_n = x_n + 1'b1;
        end else begin
          le_evt = 1'b1;
        end
      end
    end
  end

  assign pop     = lcd.out_valid && lcd.out_ready;
  assign ovf_evt = push && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked   <= 1'b0;
      x        <= '0;
      y        <= '0;
      part     <= '0;
      overflow <= 1'b0;
      line_err <= 1'b0;
    end else begin
      locked   <= locked_n;
      x        <= x_n;
      y        <= y_n;
      part     <= part_n;
      overflow <= ovf_evt | (overflow & ~err_clr);
      line_err <= le_evt | (line_err & ~err_clr);
    end
  end

  ppu_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (!disp_on),
    .push     (push),
    .wr_entry (entry),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign lcd.out_valid = !empty;
  assign lcd.out_data  = head.data;
  assign lcd.out_sof   = head.sof;
  assign lcd.out_eol   = head.eol;
endmodule

// File: tb/tb_ppu_lcd_packer.sv
// Directed scenarios plus a random phase, checked every cycle against a queue model.
module tb_ppu_lcd_packer;
  import ppu_pkg::*;

  localparam int DEPTH = 16;
  localparam int LPX   = 160;
  localparam int FL    = 144;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic disp_on = 1'b0, hsync = 1'b0, vsync = 1'b0, px_out = 1'b0, err_clr = 1'b0;
  px_t  px = 2'd0;
  logic overflow, line_err;

  ppu_lcd_packer_if bus ();

  ppu_lcd_packer #(.FIFO_DEPTH(DEPTH), .LINE_PX(LPX), .FRAME_LINES(FL)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .disp_on  (disp_on),
    .hsync    (hsync),
    .vsync    (vsync),
    .px_out   (px_out),
    .px       (px),
    .lcd      (bus),
    .overflow (overflow),
    .line_err (line_err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [9:0] e;      // {sof, eol, data}
    int         stamp;  // edge index of the push
  } ment_t;

  ment_t      mq[$];
  int         cur = 0;
  bit         m_locked = 0, m_ovf = 0, m_lerr = 0;
  int         m_x = 0, m_y = 0, m_acc = 0;
  logic [9:0] log_q[$];

  task automatic model_step();
    bit pop, oev, lev;
    int pos;
    oev = 0;
    lev = 0;
    pop = (mq.size() > 0) && (mq[0].stamp < cur) && bus.out_ready;
    cur = cur + 1;
    if (!disp_on) begin
      mq.delete();
      m_locked = 0; m_x = 0; m_y = 0; m_acc = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (vsync) begin
        m_locked = 1; m_x = 0; m_y = 0; m_acc = 0;
      end else if (hsync) begin
        if (m_x != 0 && m_x != LPX) lev = 1;
        m_x = 0;
        m_y = (m_y >= 255) ? 255 : m_y + 1;
        m_acc = 0;
      end
      if (px_out && m_locked) begin
        if (m_x < LPX && m_y < FL) begin
          pos = m_x % 4;
          if (pos == 0) m_acc = 0;
          m_acc = m_acc + int'(px) * (1 << (6 - 2 * pos));
          if (pos == 3) begin
            ment_t n;
            n.e = {(m_x == 3 && m_y == 0), (m_x == LPX - 1), 8'(m_acc)};
            n.stamp = cur;
            if (mq.size() < DEPTH) mq.push_back(n);
            else oev = 1;
          end
          m_x = m_x + 1;
        end else begin
          lev = 1;
        end
      end
    end
    m_ovf  = oev ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
    m_lerr = lev ? 1'b1 : (err_clr ? 1'b0 : m_lerr);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_locked = 0; m_ovf = 0; m_lerr = 0;
      m_x = 0; m_y = 0; m_acc = 0;
    end else begin
      model_step();
    end
  end

  // single compare process, mid-cycle
  always @(negedge clk) begin
    bit mv;
    mv = (mq.size() > 0) && (mq[0].stamp < cur);
    chk("out_valid", 32'(bus.out_valid), 32'(mv));
    if (mv) chk("head", 32'({bus.out_sof, bus.out_eol, bus.out_data}), 32'(mq[0].e));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("line_err", 32'(line_err), 32'(m_lerr));
    if (rst_n && bus.out_valid && bus.out_ready)
      log_q.push_back({bus.out_sof, bus.out_eol, bus.out_data});
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit hs, input bit vs, input bit po, input logic [1:0] p);
    @(posedge clk); #2;
    hsync = hs; vsync = vs; px_out = po; px = p; err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic clear_errs();
    @(posedge clk); #2;
    hsync = 0; vsync = 0; px_out = 0; err_clr = 1'b1;
    @(posedge clk); #2;
    err_clr = 1'b0;
  endtask

  initial begin
    int nbad, nsof, neol;
    logic [7:0] bv;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data",  32'(bus.out_data), 0);
    chk("rst_sof",   32'(bus.out_sof), 0);
    chk("rst_eol",   32'(bus.out_eol), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_lerr",  32'(line_err), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    disp_on = 1'b1;

    // pixels before the first vsync are ignored
    repeat (8) cyc(1'b0, 1'b0, 1'b1, 2'd3);
    idle(3); #1;
    chk("prelock_valid", 32'(bus.out_valid), 0);
    chk("prelock_bytes", 32'(log_q.size()), 0);
    chk("prelock_lerr",  32'(line_err), 0);

    // latency: 3,2,1,0 -> 0xE4 exactly one clk after the 4th pixel edge
    cyc(1'b1, 1'b1, 1'b1, 2'd3);
    cyc(1'b0, 1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b0, 1'b1, 2'd1);
    cyc(1'b0, 1'b0, 1'b1, 2'd0);
    @(posedge clk); #1;
    chk("lat_early_valid", 32'(bus.out_valid), 0);
    #1 px_out = 1'b0;
    @(posedge clk); #1;
    chk("lat_valid", 32'(bus.out_valid), 1);
    chk("lat_data",  32'(bus.out_data), 32'h0E4);
    chk("lat_sof",   32'(bus.out_sof), 1);
    idle(3);

    // full frame, px = x[1:0]
    log_q.delete();
    for (int yy = 0; yy < FL; yy++)
      for (int xx = 0; xx < LPX; xx++) begin
        bv = 8'(xx);
        cyc(xx == 0, (xx == 0) && (yy == 0), 1'b1, bv[1:0]);
      end
    idle(6); #1;
    nbad = 0; nsof = 0; neol = 0;
    foreach (log_q[i]) begin
      if (log_q[i][7:0] != 8'h1B) nbad++;
      if (log_q[i][9] != (i == 0)) nsof++;
      if (log_q[i][8] != ((i % 40) == 39)) neol++;
    end
    chk("frame_bytes",   32'(log_q.size()), 5760);
    chk("frame_data",    32'(nbad), 0);
    chk("frame_sof_pos", 32'(nsof), 0);
    chk("frame_eol_pos", 32'(neol), 0);
    chk("frame_ovf",     32'(overflow), 0);
    chk("frame_lerr",    32'(line_err), 0);

    // backpressure: 19 bytes into a 16-deep FIFO with ready low
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    bus.out_ready = 1'b0;
    log_q.delete();
    for (int b = 0; b < DEPTH + 3; b++) begin
      bv = 8'(b);
      cyc(1'b0, 1'b0, 1'b1, bv[7:6]);
      cyc(1'b0, 1'b0, 1'b1, bv[5:4]);
      cyc(1'b0, 1'b0, 1'b1, bv[3:2]);
      cyc(1'b0, 1'b0, 1'b1, bv[1:0]);
      idle(1); #1;
      chk($sformatf("bp_ovf_b%0d", b), 32'(overflow), 32'(b >= DEPTH));
    end
    chk("bp_hold_valid", 32'(bus.out_valid), 1);
    chk("bp_hold_data",  32'(bus.out_data), 0);
    bus.out_ready = 1'b1;
    idle(25); #1;
    chk("bp_drain_cnt", 32'(log_q.size()), DEPTH);
    nbad = 0;
    foreach (log_q[i]) if (log_q[i][7:0] != 8'(i)) nbad++;
    chk("bp_drain_order", 32'(nbad), 0);
    clear_errs(); #1;
    chk("bp_clr_ovf", 32'(overflow), 0);

    // short line of 100 pixels, then a full line of 3,2,1,0 pattern
    log_q.delete();
    for (int xx = 0; xx < 100; xx++) begin
      bv = 8'(xx);
      cyc(xx == 0, xx == 0, 1'b1, bv[1:0]);
    end
    cyc(1'b1, 1'b0, 1'b0, 2'd0);
    idle(1); #1;
    chk("short_lerr", 32'(line_err), 1);
    for (int xx = 0; xx < LPX; xx++) begin
      bv = 8'(3 - (xx % 4));
      cyc(1'b0, 1'b0, 1'b1, bv[1:0]);
    end
    idle(6); #1;
    chk("short_bytes", 32'(log_q.size()), 65);
    nbad = 0; neol = 0;
    foreach (log_q[i]) begin
      if (log_q[i][7:0] != ((i < 25) ? 8'h1B : 8'hE4)) nbad++;
      if (log_q[i][8] != (i == 64)) neol++;
    end
    chk("short_data", 32'(nbad), 0);
    chk("short_eol",  32'(neol), 0);
    clear_errs();

    // vblank: pixels at y=144 are dropped and flagged
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    repeat (FL) cyc(1'b1, 1'b0, 1'b0, 2'd0);
    idle(1); #1;
    chk("vblank_lerr_pre", 32'(line_err), 0);
    log_q.delete();
    cyc(1'b0, 1'b0, 1'b1, 2'd1);
    idle(1); #1;
    chk("vblank_lerr", 32'(line_err), 1);
    clear_errs();

    // async reset mid-line with 8 bytes buffered
    bus.out_ready = 1'b0;
    for (int xx = 0; xx < 32; xx++) begin
      bv = 8'(xx);
      cyc(xx == 0, xx == 0, 1'b1, bv[1:0]);
    end
    idle(2); #1;
    chk("mid_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_data",  32'(bus.out_data), 0);
    chk("arst_sof",   32'(bus.out_sof), 0);
    chk("arst_eol",   32'(bus.out_eol), 0);
    chk("arst_ovf",   32'(overflow), 0);
    chk("arst_lerr",  32'(line_err), 0);
    idle(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    log_q.delete();
    repeat (8) cyc(1'b0, 1'b0, 1'b1, 2'd2);
    for (int xx = 0; xx < 8; xx++) begin
      bv = 8'(xx);
      cyc(xx == 0, xx == 0, 1'b1, bv[1:0]);
    end
    idle(5); #1;
    chk("resume_bytes", 32'(log_q.size()), 2);
    if (log_q.size() == 2) begin
      chk("resume_b0", 32'(log_q[0]), 32'h21B);
      chk("resume_b1", 32'(log_q[1]), 32'h01B);
    end

    // random phase
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      disp_on       = ($urandom_range(0, 299) != 0);
      vsync         = ($urandom_range(0, 299) == 0);
      hsync         = vsync | ($urandom_range(0, 59) == 0);
      px_out        = ($urandom_range(0, 4) != 0);
      px            = 2'($urandom);
      err_clr       = ($urandom_range(0, 96) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    disp_on = 1'b1;
    bus.out_ready = 1'b1;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
